// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one WIDTH-bit AND unit among N requesters.
// Each operation runs IDLE -> EXEC -> RESP; the result returns tagged with the requester index.
module and_unit_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   op_a,
    input  logic [N*WIDTH-1:0]   op_b,
    output logic [N-1:0]         gnt,
    output logic                 busy,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [WIDTH-1:0]     rsp_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [IDW-1:0]     ptr_r;
    logic [IDW-1:0]     ptr_nxt_s;
    logic [IDW-1:0]     win_r;
    logic [IDW-1:0]     win_nxt_s;
    logic [WIDTH-1:0]   a_lat_r;
    logic [WIDTH-1:0]   a_nxt_s;
    logic [WIDTH-1:0]   b_lat_r;
    logic [WIDTH-1:0]   b_nxt_s;
    logic [N-1:0]       gnt_nxt_s;
    logic               busy_nxt_s;
    logic               rsp_valid_nxt_s;
    logic [IDW-1:0]     rsp_id_nxt_s;
    logic [WIDTH-1:0]   rsp_data_nxt_s;
    logic [IDW-1:0]     pick_s;
    logic               pick_vld_s;

    // Round-robin search from ptr; scanning offsets high-to-low lets the smallest offset win.
    always_comb begin
        int idx_v;
        idx_v      = 0;
        pick_s     = '0;
        pick_vld_s = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx_v = (int'(ptr_r) + k) % N;
            if (req[idx_v]) begin
                pick_s     = IDW'(idx_v);
                pick_vld_s = 1'b1;
            end else begin
                pick_s     = pick_s;
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_RESP;
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs and the operand/winner latches.
    always_comb begin
        gnt_nxt_s       = gnt;
        busy_nxt_s      = busy;
        rsp_valid_nxt_s = 1'b0;
        rsp_id_nxt_s    = rsp_id;
        rsp_data_nxt_s  = rsp_data;
        ptr_nxt_s       = ptr_r;
        win_nxt_s       = win_r;
        a_nxt_s         = a_lat_r;
        b_nxt_s         = b_lat_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    gnt_nxt_s  = {{(N-1){1'b0}}, 1'b1} << pick_s;
                    busy_nxt_s = 1'b1;
                    win_nxt_s  = pick_s;
                    a_nxt_s    = op_a[pick_s*WIDTH +: WIDTH];
                    b_nxt_s    = op_b[pick_s*WIDTH +: WIDTH];
                end else begin
                    gnt_nxt_s  = '0;
                    busy_nxt_s = 1'b0;
                end
            end
            ST_EXEC: begin
                rsp_data_nxt_s  = a_lat_r & b_lat_r;
                rsp_id_nxt_s    = win_r;
                rsp_valid_nxt_s = 1'b1;
            end
            ST_RESP: begin
                gnt_nxt_s  = '0;
                busy_nxt_s = 1'b0;
                ptr_nxt_s  = IDW'((int'(win_r) + 1) % N);
            end
            default: begin
                gnt_nxt_s  = '0;
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Output and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            ptr_r     <= '0;
            win_r     <= '0;
            a_lat_r   <= '0;
            b_lat_r   <= '0;
        end else begin
            gnt       <= gnt_nxt_s;
            busy      <= busy_nxt_s;
            rsp_valid <= rsp_valid_nxt_s;
            rsp_id    <= rsp_id_nxt_s;
            rsp_data  <= rsp_data_nxt_s;
            ptr_r     <= ptr_nxt_s;
            win_r     <= win_nxt_s;
            a_lat_r   <= a_nxt_s;
            b_lat_r   <= b_nxt_s;
        end
    end

endmodule
